// File: rtl/mem_arbiter.sv
// Multi-channel memory request arbiter with an in-order ID FIFO that routes answers back to their requesters.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest channel wins) instead of round-robin.
package mem_arbiter_pkg;
    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
    } mem_ans_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [N_CH-1:0] ch_valid_i,
    output logic [N_CH-1:0] ch_ready_o,
    input  mem_req_t        ch_req_i [N_CH],
    output logic [N_CH-1:0] ch_valid_o,
    input  logic [N_CH-1:0] ch_ready_i,
    output mem_ans_t        ch_ans_o [N_CH],
    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    output mem_req_t        mem_req_o,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  mem_ans_t        mem_ans_i
);

    localparam int unsigned CH_W  = $clog2(N_CH);
    localparam int unsigned PTR_W = $clog2(MAX_OUTST);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CH_W-1:0]      id_q [MAX_OUTST];
    logic [MAX_OUTST-1:0] drop_q, drop_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 lock_q, lock_d;
    logic [CH_W-1:0]      lock_ch_q, lock_ch_d;
    logic                 flush_pend_q, flush_pend_d;

    logic            fifo_full, fifo_empty, any_valid;
    logic            push, pop, stall;
    logic [CH_W-1:0] gnt, head_ch;
    logic            head_drop;

    function automatic logic [CH_W-1:0] first_set(input logic [N_CH-1:0] v);
        first_set = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) first_set = CH_W'(i);
        end
    endfunction

`ifdef MEM_ARB_FIXED_PRIO_EN
    // A stalled request keeps its grant; otherwise the lowest requesting channel wins.
    always_comb begin
        gnt = first_set(ch_valid_i);
        if (lock_q && ch_valid_i[lock_ch_q]) gnt = lock_ch_q;
    end
`else
    localparam int unsigned SUM_W = CH_W + 1;

    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_CH-1:0]  rotated;
    logic [SUM_W-1:0] rr_sum;

    // rr_ptr_q holds the channel with highest priority; search the rotated request vector from there.
    always_comb begin
        rotated = N_CH'({ch_valid_i, ch_valid_i} >> rr_ptr_q);
        rr_sum  = {1'b0, rr_ptr_q} + {1'b0, first_set(rotated)};
        if (rr_sum >= SUM_W'(N_CH)) rr_sum = rr_sum - SUM_W'(N_CH);
        gnt = rr_sum[CH_W-1:0];
        if (lock_q && ch_valid_i[lock_ch_q]) gnt = lock_ch_q;
    end
`endif

    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
    assign fifo_empty = (cnt_q == '0);
    assign any_valid  = |ch_valid_i;
    assign head_ch    = id_q[rd_ptr_q];
    assign head_drop  = drop_q[rd_ptr_q];

    always_comb begin
        for (int i = 0; i < N_CH; i++) ch_ans_o[i] = mem_ans_i;
    end

    // Handshake outputs and next-state; everything is forced quiet while reset is held.
    always_comb begin
        mem_valid_o  = !rst_i && any_valid && !fifo_full;
        mem_req_o    = ch_req_i[gnt];
        ch_ready_o   = '0;
        ch_valid_o   = '0;
        mem_ready_o  = 1'b0;
        if (mem_valid_o && mem_ready_i) ch_ready_o[gnt] = 1'b1;
        if (!rst_i && !fifo_empty) begin
            if (head_drop) begin
                mem_ready_o = 1'b1;
            end else begin
                ch_valid_o[head_ch] = mem_valid_i;
                mem_ready_o         = ch_ready_i[head_ch];
            end
        end

        push  = mem_valid_o && mem_ready_i;
        pop   = mem_valid_i && mem_ready_o;
        stall = mem_valid_o && !mem_ready_i;

        drop_d = drop_q;
        if (push) drop_d[wr_ptr_q] = flush_i || flush_pend_q;
        if (flush_i) drop_d = '1;

        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop);
        lock_d       = stall;
        lock_ch_d    = gnt;
        // A flush seen while a request is stalled must still mark it dropped once it issues.
        flush_pend_d = stall && (flush_i || flush_pend_q);
`ifndef MEM_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
        if (push) rr_ptr_d = (gnt == CH_W'(N_CH - 1)) ? '0 : gnt + CH_W'(1);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            lock_q       <= 1'b0;
            lock_ch_q    <= '0;
            flush_pend_q <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            drop_q       <= drop_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            lock_q       <= lock_d;
            lock_ch_q    <= lock_ch_d;
            flush_pend_q <= flush_pend_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) id_q[wr_ptr_q] <= gnt;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter, checked against a queue-based reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int N_CH      = 2;
    localparam int MAX_OUTST = 4;

    logic            clk = 1'b0;
    logic            rst, flush;
    logic [N_CH-1:0] ch_valid, ch_ready_o, ch_valid_o, ch_ready;
    mem_req_t        ch_req [N_CH];
    mem_ans_t        ch_ans [N_CH];
    logic            mem_valid_o, mem_ready, mem_valid_in, mem_ready_o;
    mem_req_t        mem_req_o;
    mem_ans_t        mem_ans;

    mem_arbiter #(.N_CH(N_CH), .MAX_OUTST(MAX_OUTST)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .ch_valid_i (ch_valid),
        .ch_ready_o (ch_ready_o),
        .ch_req_i   (ch_req),
        .ch_valid_o (ch_valid_o),
        .ch_ready_i (ch_ready),
        .ch_ans_o   (ch_ans),
        .mem_valid_o(mem_valid_o),
        .mem_ready_i(mem_ready),
        .mem_req_o  (mem_req_o),
        .mem_valid_i(mem_valid_in),
        .mem_ready_o(mem_ready_o),
        .mem_ans_i  (mem_ans)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        bit drop;
    } ent_t;

    ent_t outq[$];
    int   last_gnt = N_CH - 1;
    int   lock_ch  = -1;
    bit   pend     = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference arbitration: stalled request keeps the grant, else priority rule from the last grant.
    function automatic int model_pick();
        if (lock_ch >= 0 && ch_valid[lock_ch]) return lock_ch;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_CH; i++) if (ch_valid[i]) return i;
`else
        for (int k = 1; k <= N_CH; k++) begin
            if (ch_valid[(last_gnt + k) % N_CH]) return (last_gnt + k) % N_CH;
        end
`endif
        return -1;
    endfunction

    // Compare DUT outputs with the model for the current inputs, then advance the model by one edge.
    task automatic settle();
        int              g;
        bit              exp_mv, exp_mr, do_push, do_pop, stalled;
        logic [N_CH-1:0] exp_crdy, exp_cval;
        #1;
        exp_crdy = '0;
        exp_cval = '0;
        exp_mr   = 1'b0;
        g        = model_pick();
        exp_mv   = !rst && (g >= 0) && (outq.size() < MAX_OUTST);
        if (exp_mv && mem_ready) exp_crdy[g] = 1'b1;
        if (!rst && outq.size() > 0) begin
            if (outq[0].drop) exp_mr = 1'b1;
            else begin
                exp_cval[outq[0].ch] = mem_valid_in;
                exp_mr               = ch_ready[outq[0].ch];
            end
        end
        check("mem_valid_o", 64'(mem_valid_o), 64'(exp_mv));
        check("ch_ready_o", 64'(ch_ready_o), 64'(exp_crdy));
        check("mem_ready_o", 64'(mem_ready_o), 64'(exp_mr));
        check("ch_valid_o", 64'(ch_valid_o), 64'(exp_cval));
        if (exp_mv) check("mem_req_o", 64'(mem_req_o), 64'(ch_req[g]));
        for (int i = 0; i < N_CH; i++) check("ch_ans_o", 64'(ch_ans[i]), 64'(mem_ans));

        if (rst) begin
            outq.delete();
            last_gnt = N_CH - 1;
            lock_ch  = -1;
            pend     = 1'b0;
        end else begin
            do_push = exp_mv && mem_ready;
            do_pop  = mem_valid_in && exp_mr;
            stalled = exp_mv && !mem_ready;
            if (do_pop) void'(outq.pop_front());
            if (flush) foreach (outq[i]) outq[i].drop = 1'b1;
            if (do_push) begin
                outq.push_back('{ch: g, drop: flush || pend});
                last_gnt = g;
            end
            lock_ch = stalled ? g : -1;
            pend    = stalled && (flush || pend);
        end
    endtask

    task automatic idle_inputs();
        rst          = 1'b0;
        flush        = 1'b0;
        ch_valid     = '0;
        ch_ready     = '0;
        mem_ready    = 1'b0;
        mem_valid_in = 1'b0;
    endtask

    task automatic cycle();
        settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic rand_payload(input int ch);
        ch_req[ch].addr  = 16'($urandom);
        ch_req[ch].we    = 1'($urandom);
        ch_req[ch].wdata = $urandom;
    endtask

    initial begin
        idle_inputs();
        mem_ans = '{rdata: 32'hA5A5_0001};
        for (int i = 0; i < N_CH; i++) rand_payload(i);
        @(negedge clk);
        rst = 1'b1;
        cycle();
        settle();
        check("rst_mem_valid", 64'(mem_valid_o), 64'(0));
        check("rst_mem_ready", 64'(mem_ready_o), 64'(0));
        @(negedge clk);

        // Both channels held: alternating grants (fixed priority: channel 0 always).
        do_reset();
        ch_valid = 2'b11; mem_ready = 1'b1; mem_valid_in = 1'b1; ch_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            settle();
`ifdef MEM_ARB_FIXED_PRIO_EN
            check("fixed_gnt", 64'(ch_ready_o), 64'(2'b01));
`else
            check("rr_gnt", 64'(ch_ready_o), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
`endif
            @(negedge clk);
        end

        // Locked grant while memory stalls, channel 0 joins late.
        do_reset();
        ch_valid = 2'b10; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) ch_valid = 2'b11;
            settle();
            check("lock_req", 64'(mem_req_o), 64'(ch_req[1]));
            @(negedge clk);
        end
        mem_ready = 1'b1;
        settle();
        check("lock_accept", 64'(ch_ready_o), 64'(2'b10));
        @(negedge clk);
        settle();
        check("after_lock_gnt", 64'(ch_ready_o), 64'(2'b01));
        @(negedge clk);

        // Fill the FIFO, then one answer frees a slot (no bypass in the same cycle).
        do_reset();
        ch_valid = 2'b01; mem_ready = 1'b1;
        for (int i = 0; i < MAX_OUTST; i++) cycle();
        settle();
        check("full_block", 64'(mem_valid_o), 64'(0));
        @(negedge clk);
        mem_valid_in = 1'b1; ch_ready = 2'b11;
        settle();
        check("no_bypass", 64'(mem_valid_o), 64'(0));
        check("full_pop", 64'(mem_ready_o), 64'(1));
        @(negedge clk);
        mem_valid_in = 1'b0;
        settle();
        check("resume", 64'(mem_valid_o), 64'(1));
        @(negedge clk);

        // Three outstanding, flush, then all answers are swallowed.
        do_reset();
        mem_ready = 1'b1;
        ch_valid = 2'b01; cycle();
        ch_valid = 2'b10; cycle();
        ch_valid = 2'b01; cycle();
        ch_valid = 2'b00; flush = 1'b1; cycle();
        flush = 1'b0; mem_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("flush_ready", 64'(mem_ready_o), 64'(1));
            check("flush_cvalid", 64'(ch_valid_o), 64'(0));
            @(negedge clk);
        end
        settle();
        check("flush_empty", 64'(mem_ready_o), 64'(0));
        @(negedge clk);

        // Answer backpressure from channel 1.
        do_reset();
        mem_ready = 1'b1; ch_valid = 2'b10; cycle();
        ch_valid = 2'b00; mem_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ch_ready = (i == 2) ? 2'b10 : 2'b00;
            settle();
            check("bp_ready", 64'(mem_ready_o), 64'((i == 2) ? 1 : 0));
            check("bp_cvalid", 64'(ch_valid_o), 64'(2'b10));
            @(negedge clk);
        end
        settle();
        check("bp_popped", 64'(ch_valid_o), 64'(0));
        @(negedge clk);

        // Reset mid-transaction drops outstanding entries.
        do_reset();
        mem_ready = 1'b1; ch_valid = 2'b11; cycle(); cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; ch_valid = 2'b00; mem_valid_in = 1'b1; ch_ready = 2'b11;
        settle();
        check("rst_discard", 64'(mem_ready_o), 64'(0));
        check("rst_discard_cv", 64'(ch_valid_o), 64'(0));
        @(negedge clk);

        // Randomized traffic; a stalled channel keeps its request and payload stable.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst          = ($urandom_range(0, 299) == 0);
            flush        = ($urandom_range(0, 15) == 0);
            ch_valid     = N_CH'($urandom);
            mem_ready    = ($urandom_range(0, 3) != 0);
            mem_valid_in = ($urandom_range(0, 2) != 0);
            ch_ready     = N_CH'($urandom);
            mem_ans      = '{rdata: $urandom};
            for (int i = 0; i < N_CH; i++) begin
                if (i == lock_ch) ch_valid[i] = 1'b1;
                else rand_payload(i);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL provide parameter N_CH, default 2, as the number of requester channels (legal range 2..8; channel 0 = fetch, 1 = load-store).
REQ-002 The block SHALL provide parameter MAX_OUTST, default 4, as the maximum number of issued requests awaiting an answer (power of two, 2..16).
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 flush_i  in  1  pipeline flush from main control unit.
REQ-006 ch_valid_i / ch_ready_o  in/out  N_CH  per-channel request handshake.
REQ-007 ch_req_i  in  N_CH x mem_req_t  per-channel request payload.
REQ-008 ch_valid_o / ch_ready_i  out/in  N_CH  per-channel answer handshake.
REQ-009 ch_ans_o  out  N_CH x mem_ans_t  answer payload; every entry is a copy of mem_ans_i.
REQ-010 mem_valid_o / mem_ready_i  out/in  1  request handshake to memory.
REQ-011 mem_req_o  out  mem_req_t  payload of the granted channel.
REQ-012 mem_valid_i / mem_ready_o  in/out  1  answer handshake from memory; memory answers in issue order.

Function
REQ-013 Request transfer SHALL occur when mem_valid_o && mem_ready_i; answer transfer when mem_valid_i && mem_ready_o.
REQ-014 Grant SHALL go to one requesting channel, chosen round-robin: priority starts at the channel after the last granted one, wrapping from N_CH-1 to 0.
REQ-015 mem_valid_o SHALL equal (any ch_valid_i) && !fifo_full; ch_ready_o[g] = mem_ready_i && !fifo_full for the granted channel g only, 0 for others.
REQ-016 If mem_valid_o is high and mem_ready_i low, the grant SHALL be locked to the same channel next cycle, regardless of other requesters.
REQ-017 The round-robin pointer SHALL advance only on a request transfer.
REQ-018 Each request transfer SHALL push {channel index, drop=0} into an in-order ID FIFO of depth MAX_OUTST.
REQ-019 With the FIFO full, no grant SHALL be issued, even if an answer pops in the same cycle (no bypass).
REQ-020 With the FIFO empty, mem_ready_o SHALL be 0 and all ch_valid_o SHALL be 0.
REQ-021 With the FIFO non-empty and head = {c, drop}: if drop=0, ch_valid_o[c] = mem_valid_i and mem_ready_o = ch_ready_i[c]; if drop=1, ch_valid_o = 0 and mem_ready_o = 1.
REQ-022 An answer transfer SHALL pop the FIFO head; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-023 Answer routing SHALL be combinational (zero latency); request issue latency SHALL be zero cycles after ch_valid_i when the channel wins and the FIFO is not full.
REQ-024 flush_i high SHALL set drop=1 on every FIFO entry, including one pushed in the same cycle.
REQ-025 flush_i SHALL NOT abort a locked, unaccepted request; it completes and is marked drop=1.
REQ-026 Occupancy counter SHALL be $clog2(MAX_OUTST)+1 bits; FIFO pointers SHALL wrap modulo MAX_OUTST.

Reset
REQ-027 While rst_i is high, FIFO SHALL empty, all drop bits clear, grant lock clear, and round-robin pointer SHALL reset so channel 0 has highest priority.
REQ-028 While rst_i is high, mem_valid_o, mem_ready_o, all ch_ready_o and all ch_valid_o SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL discard all outstanding entries; no answer is forwarded for them afterwards.

Configuration
REQ-030 When MEM_ARB_FIXED_PRIO_EN is defined, the grant SHALL be fixed priority, lowest channel index wins, and the round-robin pointer SHALL be removed; REQ-016 locking still applies.
REQ-031 When MEM_ARB_FIXED_PRIO_EN is not defined, the grant SHALL be round-robin per REQ-014 and REQ-017.

Verification
REQ-032 N_CH=2: ch_valid_i=2'b11 held, mem_ready_i=1, answers always returned -> grants alternate 0,1,0,1 starting with channel 0 after reset.
REQ-033 Channel 1 requests with mem_ready_i=0 for 3 cycles while channel 0 rises in cycle 2 -> mem_req_o stays channel 1's payload until accepted; channel 0 is granted next.
REQ-034 MAX_OUTST=4: 4 requests issued, no answers -> 5th request blocked with mem_valid_o=0; one answer then frees a slot, and the grant resumes in the following cycle.
REQ-035 3 outstanding (ch0, ch1, ch0), flush_i pulse, then 3 answers -> all popped with mem_ready_o=1 and ch_valid_o=0 throughout.
REQ-036 Answer for ch1 at head with ch_ready_i[1]=0 for 2 cycles -> mem_ready_o=0 for 2 cycles; the transfer completes on the 3rd cycle.
REQ-037 MEM_ARB_FIXED_PRIO_EN defined, ch_valid_i=2'b11 held -> channel 0 is granted every cycle.
